// File: rtl/harris_corner_locator.sv
// harris_corner_locator: per-frame strongest-corner search and corner count over the Harris response stream.
// Tracks raster position from VGA timing and publishes the results on each vertical sync.
module harris_corner_locator #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_OFFSET = 3,
  parameter int Y_OFFSET = 2,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    VGA_BLANK_N,
  input  logic                    VGA_VS,
  input  logic signed [53:0]      harris_feature,
  input  logic signed [53:0]      threshold,
  output logic                    corner_hit,
  output logic [9:0]              corner_x,
  output logic [8:0]              corner_y,
  output logic signed [53:0]      corner_max,
  output logic [CNT_W-1:0]        corner_count,
  output logic                    corner_valid,
  output logic                    frame_done
);
  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;
  localparam logic [9:0]  XO = 10'(X_OFFSET);
  localparam logic [8:0]  YO = 9'(Y_OFFSET);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [9:0]  VA = 10'(V_ACTIVE);

  logic                   vs_q, blank_q;
  logic [9:0]             raw_x_q, raw_x_d, sx;
  logic [8:0]             raw_y_q, raw_y_d, sy;
  logic [1:0]             state_q, state_d;
  logic signed [53:0]     thr_q, work_max_q;
  logic [9:0]             work_x_q;
  logic [8:0]             work_y_q;
  logic [CNT_W-1:0]       work_cnt_q;
  logic                   found_q;
  logic                   vs_fall, blank_fall, qual, hit, take, clr;

  always_comb begin
    vs_fall    = vs_q & ~VGA_VS;
    blank_fall = blank_q & ~VGA_BLANK_N;
    sx         = raw_x_q - XO;
    sy         = raw_y_q - YO;
    qual       = VGA_BLANK_N & (raw_x_q >= XO) & (raw_y_q >= YO) & ({1'b0, sx} < HA) & ({1'b0, sy} < VA);
    hit        = qual & (harris_feature > thr_q);
    // strict compare keeps the first raster occurrence on ties
    take       = hit & (~found_q | (harris_feature > work_max_q));
    clr        = (state_q == S_WAIT && vs_fall) || state_q == S_REPORT;
    raw_x_d    = (vs_fall | blank_fall) ? 10'd0 : (VGA_BLANK_N && raw_x_q != 10'h3FF) ? raw_x_q + 10'd1 : raw_x_q;
    raw_y_d    = vs_fall ? 9'd0 : (blank_fall && raw_y_q != 9'h1FF) ? raw_y_q + 9'd1 : raw_y_q;
    state_d    = (state_q == S_ACTIVE) ? (vs_fall ? S_REPORT : S_ACTIVE) :
                 (state_q == S_WAIT)   ? (vs_fall ? S_ACTIVE : S_WAIT) : S_ACTIVE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q         <= 1'b1;
      blank_q      <= 1'b1;
      raw_x_q      <= '0;
      raw_y_q      <= '0;
      state_q      <= S_WAIT;
      thr_q        <= '0;
      work_max_q   <= '0;
      work_x_q     <= '0;
      work_y_q     <= '0;
      work_cnt_q   <= '0;
      found_q      <= 1'b0;
      corner_hit   <= 1'b0;
      corner_x     <= '0;
      corner_y     <= '0;
      corner_max   <= '0;
      corner_count <= '0;
      corner_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      vs_q       <= VGA_VS;
      blank_q    <= VGA_BLANK_N;
      raw_x_q    <= raw_x_d;
      raw_y_q    <= raw_y_d;
      state_q    <= state_d;
      corner_hit <= hit;
      frame_done <= state_q == S_REPORT;
      if (state_q == S_REPORT) begin
        corner_x     <= work_x_q;
        corner_y     <= work_y_q;
        corner_max   <= work_max_q;
        corner_count <= work_cnt_q;
        corner_valid <= found_q;
      end
      if (clr) begin
        thr_q      <= threshold;
        work_max_q <= '0;
        work_x_q   <= '0;
        work_y_q   <= '0;
        work_cnt_q <= '0;
        found_q    <= 1'b0;
      end else if (state_q == S_ACTIVE && hit) begin
        work_cnt_q <= (work_cnt_q != '1) ? work_cnt_q + 1'b1 : work_cnt_q;
        found_q    <= 1'b1;
        if (take) begin
          work_max_q <= harris_feature;
          work_x_q   <= sx;
          work_y_q   <= sy;
        end
      end
    end
  end
endmodule

// File: tb/tb_harris_corner_locator.sv
// tb_harris_corner_locator: directed raster frames with hand-computed corner reports.
module tb_harris_corner_locator;
  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               VGA_BLANK_N = 1'b0;
  logic               VGA_VS = 1'b1;
  logic signed [53:0] harris_feature = '0;
  logic signed [53:0] threshold = '0;
  logic               corner_hit;
  logic [9:0]         corner_x;
  logic [8:0]         corner_y;
  logic signed [53:0] corner_max;
  logic [15:0]        corner_count;
  logic               corner_valid;
  logic               frame_done;

  int n_chk = 0;
  int n_pass = 0;
  int fd_cnt = 0;
  int hit_cnt = 0;
  int nf = 0;
  int fxa[4];
  int fya[4];
  logic signed [53:0] fva[4];

  harris_corner_locator dut (
    .clk(clk), .reset(reset), .VGA_BLANK_N(VGA_BLANK_N), .VGA_VS(VGA_VS),
    .harris_feature(harris_feature), .threshold(threshold), .corner_hit(corner_hit),
    .corner_x(corner_x), .corner_y(corner_y), .corner_max(corner_max),
    .corner_count(corner_count), .corner_valid(corner_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (corner_hit) hit_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [53:0] feat(input int x, input int y);
    logic signed [53:0] v = '0;
    for (int i = 0; i < nf; i++)
      if (fxa[i] == x && fya[i] == y) v = fva[i];
    return v;
  endfunction

  // full == 0 makes feature-free lines one pixel long to keep tall frames short
  task automatic lines(input int y0, input int n, input int full);
    for (int y = y0; y < y0 + n; y++) begin
      int len = full;
      if (full == 0) begin
        len = 1;
        for (int i = 0; i < nf; i++)
          if (fya[i] == y && fxa[i] + 1 > len) len = fxa[i] + 1;
      end
      VGA_BLANK_N = 1'b1;
      for (int x = 0; x < len; x++) begin
        harris_feature = feat(x, y);
        tick();
      end
      VGA_BLANK_N = 1'b0;
      harris_feature = '0;
      tick();
    end
  endtask

  task automatic vsync();
    VGA_BLANK_N = 1'b0;
    harris_feature = '0;
    VGA_VS = 1'b0;
    repeat (3) tick();
    VGA_VS = 1'b1;
    tick();
  endtask

  task automatic start(input logic signed [53:0] thr);
    threshold = thr;
    vsync();
    fd_cnt = 0;
    hit_cnt = 0;
  endtask

  task automatic report(input string tag, input int x, input int y, input logic signed [53:0] m, input int cnt, input logic v);
    vsync();
    chk({tag, "_fd"}, fd_cnt, 1);
    chk({tag, "_x"}, corner_x, x);
    chk({tag, "_y"}, corner_y, y);
    chk({tag, "_max"}, corner_max, m);
    chk({tag, "_cnt"}, corner_count, cnt);
    chk({tag, "_valid"}, corner_valid, v);
    fd_cnt = 0;
    hit_cnt = 0;
  endtask

  initial begin
    #2;
    chk("rst_out", {corner_hit, corner_x, corner_y, corner_max, corner_count, corner_valid, frame_done}, 0);
    tick();
    reset = 1'b1;
    tick();

    nf = 1; fxa[0] = 103; fya[0] = 52; fva[0] = 5000;
    start(1000);
    lines(0, 60, 0);
    chk("single_hits", hit_cnt, 1);
    report("single", 100, 50, 5000, 1, 1'b1);
    repeat (3) tick();
    chk("single_fd_width", fd_cnt, 0);

    nf = 2; fxa[0] = 13; fya[0] = 12; fva[0] = 7000; fxa[1] = 203; fya[1] = 302; fva[1] = 7000;
    start(1000);
    lines(0, 305, 0);
    report("tie", 10, 10, 7000, 2, 1'b1);
    fva[1] = 7001;
    start(1000);
    lines(0, 305, 0);
    report("peak2", 200, 300, 7001, 2, 1'b1);

    nf = 0;
    start(-1);
    lines(0, 105, 643);
    report("sat", 0, 0, 0, 65535, 1'b1);

    nf = 2; fxa[0] = 2; fya[0] = 5; fva[0] = 9000; fxa[1] = 643; fya[1] = 5; fva[1] = 9000;
    start(1000);
    lines(0, 8, 0);
    chk("edge_hits", hit_cnt, 0);
    report("edge", 0, 0, 0, 0, 1'b0);

    nf = 1; fxa[0] = 20; fya[0] = 10; fva[0] = 500;
    start(1000);
    lines(0, 5, 0);
    threshold = 100;
    lines(5, 10, 0);
    report("thr_hold", 0, 0, 0, 0, 1'b0);
    lines(0, 15, 0);
    report("thr_new", 17, 8, 500, 1, 1'b1);

    fva[0] = 5000;
    start(1000);
    lines(0, 5, 0);
    reset = 1'b0;
    #1;
    chk("midrst_out", {corner_hit, corner_x, corner_y, corner_max, corner_count, corner_valid, frame_done}, 0);
    repeat (3) tick();
    reset = 1'b1;
    lines(5, 10, 0);
    fd_cnt = 0;
    vsync();
    chk("midrst_arm_fd", fd_cnt, 0);
    nf = 0;
    lines(0, 15, 0);
    report("midrst", 0, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
